// File: rtl/bcd_count99.sv
// bcd_count99: two-digit BCD up/down counter with prescaler.
// Registered digits, tick and wrap; load clamps nibbles to 9.
module bcd_count99 #(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       up,
   input  logic       load,
   input  logic [3:0] load_ones,
   input  logic [3:0] load_tens,
   output logic [3:0] digit1,
   output logic [3:0] digit2,
   output logic       tick,
   output logic       wrap
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] pcnt;
   logic [3:0]    ones;
   logic [3:0]    tens;
   logic [3:0]    ones_nx;
   logic [3:0]    tens_nx;
   logic [3:0]    ld_ones;
   logic [3:0]    ld_tens;
   logic          wrap_nx;
   logic          step;

   assign step   = enable && (pcnt == LAST);
   assign digit1 = ones;
   assign digit2 = tens;

   // clamp out-of-range load nibbles to 9 so digits stay BCD
   always_comb begin
      ld_ones = (load_ones > 4'd9) ? 4'd9 : load_ones;
      ld_tens = (load_tens > 4'd9) ? 4'd9 : load_tens;
   end

   // next count for one step in the requested direction
   always_comb begin
      ones_nx = ones;
      tens_nx = tens;
      wrap_nx = 1'b0;
      if (up) begin
         if (ones < 4'd9) begin
            ones_nx = ones + 4'd1;
         end else begin
            ones_nx = 4'd0;
            if (tens < 4'd9) begin
               tens_nx = tens + 4'd1;
            end else begin
               tens_nx = 4'd0;
               wrap_nx = 1'b1;
            end
         end
      end else begin
         if (ones > 4'd0) begin
            ones_nx = ones - 4'd1;
         end else begin
            ones_nx = 4'd9;
            if (tens > 4'd0) begin
               tens_nx = tens - 4'd1;
            end else begin
               tens_nx = 4'd9;
               wrap_nx = 1'b1;
            end
         end
      end
   end

   // reset > load > step > hold; pcnt frozen while disabled
   always_ff @(posedge clock) begin
      if (reset) begin
         pcnt <= '0;
         ones <= 4'd0;
         tens <= 4'd0;
         tick <= 1'b0;
         wrap <= 1'b0;
      end else if (load) begin
         pcnt <= '0;
         ones <= ld_ones;
         tens <= ld_tens;
         tick <= 1'b0;
         wrap <= 1'b0;
      end else begin
         tick <= 1'b0;
         wrap <= 1'b0;
         if (step) begin
            pcnt <= '0;
            ones <= ones_nx;
            tens <= tens_nx;
            tick <= 1'b1;
            wrap <= wrap_nx;
         end else if (enable) begin
            pcnt <= pcnt + PW'(1);
         end
      end
   end

endmodule

// File: doc/bcd_count99.md
# bcd_count99

Two-digit BCD counter (00–99) that produces the `digit1`/`digit2` pair consumed by the display digit-select/refresh logic of the 0–99 counter design. It has an internal prescaler that advances the count once every `TICK_DIV` enabled clock cycles. The count runs up or down, wraps at 99/00 and supports a synchronous parallel load. Outputs are registered, stable BCD values, safe to multiplex at any refresh rate.

## Interface
- `TICK_DIV`, default 100_000_000: enabled clock cycles per count step. Legal range is ≥1; 1 steps every enabled cycle.
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  high lets the prescaler run; low freezes the prescaler and count.
- `up`  in  1  1 = count up, 0 = count down; sampled on the step edge.
- `load`  in  1  synchronous parallel load strobe.
- `load_ones`  in  4  BCD ones value for load.
- `load_tens`  in  4  BCD tens value for load.
- `digit1`  out  4  ones digit, BCD 0–9.
- `digit2`  out  4  tens digit, BCD 0–9.
- `tick`  out  1  one-cycle pulse; marks a count step.
- `wrap`  out  1  one-cycle pulse; marks a 99→00 (up) or 00→99 (down) step.

## Operation
- **Registers**
  - Prescaler `pcnt` is `$clog2(TICK_DIV)` bits wide, minimum 1 bit.
  - `ones` and `tens` are 4-bit BCD registers, driven directly onto `digit1` and `digit2`.
- **Priority per edge:** `reset` > `load` > step > hold.
- **Reset:** `pcnt`=0, `digit1`=0, `digit2`=0, `tick`=0, `wrap`=0.
- **Load**
  - `ones`←`load_ones` and `tens`←`load_tens`; a nibble >9 is clamped to 9.
  - `pcnt`←0; `tick`=0 and `wrap`=0 on the following cycle.
  - Load wins over a coincident step, and that step is discarded.
- **Prescaler**
  - When `enable`=1 and `pcnt`=TICK_DIV−1: `pcnt`←0 and a step occurs.
  - Otherwise, when `enable`=1: `pcnt`←`pcnt`+1.
  - When `enable`=0: `pcnt` holds.
- **Step up**
  - `ones`<9: `ones`+1.
  - Otherwise `ones`←0 and `tens` increments; `tens`=9 becomes 0 and sets `wrap`.
- **Step down**
  - `ones`>0: `ones`−1.
  - Otherwise `ones`←9 and `tens` decrements; `tens`=0 becomes 9 and sets `wrap`.
- **`up` input:** only its value on the step edge matters. Changing `up` mid-interval does not reset the prescaler.
- **Output range:** `digit1` and `digit2` never leave 0–9 after any sequence of inputs.

## Timing
- `tick` and `wrap` are registered and are high for exactly one cycle: the cycle in which the new count first appears on the digits.
- Step latency is one cycle. The edge where `pcnt` reaches TICK_DIV−1 with `enable`=1 updates the digits and raises `tick`.
- Load latency is one cycle. The loaded value is visible in the cycle after the `load` edge.
- With `enable` held high, steps are exactly TICK_DIV cycles apart. For TICK_DIV=1, `tick` is continuously high and the count changes every cycle.
- Dropping `enable` for N cycles delays the next step by exactly N cycles, because `pcnt` is preserved.
- Reset asserted mid-interval clears the partial prescale. The first step after release comes TICK_DIV enabled cycles later.
- No combinational path from any input to any output.

## Test plan
All scenarios use TICK_DIV=4 unless stated.

- **Reset and count up:** reset, then `enable`=1, `up`=1.
  - The digits read 00, then 01, 02, … with one change every 4 cycles.
  - `tick` pulses once per step; `wrap`=0 throughout.
- **Up wrap:** load 98, then count up.
  - Digits go 98 → 99 → 00.
  - `wrap`=1 only in the cycle where 00 first appears; the next step gives 01.
- **Down wrap and borrow:** load 10, `up`=0.
  - Digits go 10 → 09 → … → 00 → 99, then 98.
  - `wrap` pulses only on the 00→99 step.
- **Load priority and clamp:** assert `load` with `load_tens`=4'hC, `load_ones`=4'h5 on the same edge a step would occur.
  - Digits become 95, with `tick`=0 and `wrap`=0.
  - The next step comes 4 cycles after the load.
- **Enable gating:** deassert `enable` for 7 cycles mid-interval.
  - Digits and `tick` stay frozen.
  - The step lands exactly 7 cycles later than it would have without the gap.
- **TICK_DIV=1 and reset mid-run:** with TICK_DIV=1, count up from 00.
  - The digits change every cycle and `tick` stays high.
  - Assert reset at count 37: the next cycle shows 00 with `tick`=0.
